// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, bubble encoding and
// hazard FSM states for the ID/EX stage.
package pipe_pkg;

    localparam int CTRL_W     = 10;

    localparam int REGWRITE_B = 0;
    localparam int MEMREAD_B  = 1;
    localparam int MEMWRITE_B = 2;
    localparam int REGDST_B   = 3;
    localparam int ALUSRC_B   = 4;
    localparam int ALUOP_LSB  = 5;
    localparam int ALUOP_W    = 4;
    localparam int BRANCH_B   = 9;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use / branch-in-ID hazard check; reports whether a stall
// is needed and how many cycles it must last (1 or 2).
module hazard_detect (
    input  logic       id_valid_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       id_is_branch_i,
    input  logic       ex_memread_i,
    input  logic       ex_regwrite_i,
    input  logic [4:0] ex_dst_i,
    input  logic       mem_regwrite_i,
    input  logic [4:0] mem_dst_i,
    output logic       stall_o,
    output logic [1:0] len_o
);

    logic load_use;
    logic br_ex;
    logic br_mem;

    always_comb begin
        load_use = id_valid_i && ex_memread_i && (ex_dst_i != 5'd0) &&
                   ((ex_dst_i == id_rs_i) || (id_uses_rt_i && (ex_dst_i == id_rt_i)));
        // beq/bne compare both operands in ID, so rt always counts for branches
        br_ex    = id_valid_i && id_is_branch_i && ex_regwrite_i && (ex_dst_i != 5'd0) &&
                   ((ex_dst_i == id_rs_i) || (ex_dst_i == id_rt_i));
        br_mem   = id_valid_i && id_is_branch_i && mem_regwrite_i && (mem_dst_i != 5'd0) &&
                   ((mem_dst_i == id_rs_i) || (mem_dst_i == id_rt_i));

        stall_o  = load_use || br_ex || br_mem;
        if (br_ex) begin
            len_o = 2'd2;
        end else if (load_use || br_mem) begin
            len_o = 2'd1;
        end else begin
            len_o = 2'd0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard-stall FSM. Define HAZARD_STATS_EN to add
// the saturating stall-cycle counter output stall_cnt_o.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = pipe_pkg::CTRL_W
`ifdef HAZARD_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [4:0]        id_rs_i,
    input  logic [4:0]        id_rt_i,
    input  logic [4:0]        id_rd_i,
    input  logic              id_uses_rt_i,
    input  logic              id_is_branch_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              mem_regwrite_i,
    input  logic [4:0]        mem_dst_i,
    input  logic              flush_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              ex_valid_o,
    output logic [4:0]        ex_rs_o,
    output logic [4:0]        ex_rt_o,
    output logic [4:0]        ex_rd_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [CTRL_W-1:0] ex_ctrl_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt_o
`endif
);
    import pipe_pkg::*;

    hz_state_e         state_q, state_d;
    logic [1:0]        rem_q, rem_d;
    logic              stall;
    logic              bubble;
    logic              hz_stall;
    logic [1:0]        hz_len;
    logic [4:0]        ex_dst;

    logic              valid_q;
    logic [4:0]        rs_q, rt_q, rd_q;
    logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
    logic [CTRL_W-1:0] ctrl_q;

    assign ex_dst = ctrl_q[REGDST_B] ? rd_q : rt_q;

    hazard_detect u_hazard (
        .id_valid_i     (id_valid_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_uses_rt_i   (id_uses_rt_i),
        .id_is_branch_i (id_is_branch_i),
        .ex_memread_i   (ctrl_q[MEMREAD_B]),
        .ex_regwrite_i  (ctrl_q[REGWRITE_B]),
        .ex_dst_i       (ex_dst),
        .mem_regwrite_i (mem_regwrite_i),
        .mem_dst_i      (mem_dst_i),
        .stall_o        (hz_stall),
        .len_o          (hz_len)
    );

    // The detection cycle is itself the first stall cycle, so STALL only
    // covers the cycles that remain after it.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        stall   = 1'b0;
        if (flush_i) begin
            state_d = RUN;
            rem_d   = 2'd0;
        end else if (state_q == STALL) begin
            stall = 1'b1;
            rem_d = rem_q - 2'd1;
            if (rem_q <= 2'd1) begin
                state_d = RUN;
                rem_d   = 2'd0;
            end
        end else if (hz_stall) begin
            stall = 1'b1;
            if (hz_len > 2'd1) begin
                state_d = STALL;
                rem_d   = hz_len - 2'd1;
            end
        end
    end

    assign bubble        = flush_i || stall;
    assign pc_write_o    = !stall;
    assign if_id_write_o = !stall;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= RUN;
            rem_q     <= 2'd0;
            valid_q   <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            valid_q   <= id_valid_i && !bubble;
            rs_q      <= id_rs_i;
            rt_q      <= id_rt_i;
            rd_q      <= id_rd_i;
            rs_data_q <= id_rs_data_i;
            rt_data_q <= id_rt_data_i;
            imm_q     <= id_imm_i;
            ctrl_q    <= (bubble || !id_valid_i) ? '0 : id_ctrl_i;
        end
    end

    assign ex_valid_o   = valid_q;
    assign ex_rs_o      = rs_q;
    assign ex_rt_o      = rt_q;
    assign ex_rd_o      = rd_q;
    assign ex_rs_data_o = rs_data_q;
    assign ex_rt_data_o = rt_data_q;
    assign ex_imm_o     = imm_q;
    assign ex_ctrl_o    = ctrl_q;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (!pc_write_o && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign stall_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios plus random
// instruction streams checked against a cycle-count reference model.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid_i, id_uses_rt_i, id_is_branch_i;
    logic [4:0]    id_rs_i, id_rt_i, id_rd_i;
    logic [DW-1:0] id_rs_data_i, id_rt_data_i, id_imm_i;
    logic [CW-1:0] id_ctrl_i;
    logic          mem_regwrite_i;
    logic [4:0]    mem_dst_i;
    logic          flush_i;
    logic          pc_write_o, if_id_write_o, ex_valid_o;
    logic [4:0]    ex_rs_o, ex_rt_o, ex_rd_o;
    logic [DW-1:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o;
    logic [CW-1:0] ex_ctrl_o;
`ifdef HAZARD_STATS_EN
    logic [15:0]   stall_cnt_o;
    int            m_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .id_valid_i     (id_valid_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_rd_i        (id_rd_i),
        .id_uses_rt_i   (id_uses_rt_i),
        .id_is_branch_i (id_is_branch_i),
        .id_rs_data_i   (id_rs_data_i),
        .id_rt_data_i   (id_rt_data_i),
        .id_imm_i       (id_imm_i),
        .id_ctrl_i      (id_ctrl_i),
        .mem_regwrite_i (mem_regwrite_i),
        .mem_dst_i      (mem_dst_i),
        .flush_i        (flush_i),
        .pc_write_o     (pc_write_o),
        .if_id_write_o  (if_id_write_o),
        .ex_valid_o     (ex_valid_o),
        .ex_rs_o        (ex_rs_o),
        .ex_rt_o        (ex_rt_o),
        .ex_rd_o        (ex_rd_o),
        .ex_rs_data_o   (ex_rs_data_o),
        .ex_rt_data_o   (ex_rt_data_o),
        .ex_imm_o       (ex_imm_o),
        .ex_ctrl_o      (ex_ctrl_o)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    typedef struct packed {
        logic          valid;
        logic [4:0]    rs, rt, rd;
        logic [DW-1:0] a, b, imm;
        logic [CW-1:0] ctrl;
    } ex_t;

    typedef struct packed {
        ex_t ex;
        logic chk_fields;
    } exp_t;

    bit   pcw_q[$];
    exp_t ex_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: EX contents, EX/MEM dst as it would be in a real pipe,
    // and the number of further stall cycles still owed.
    ex_t        m_ex;
    logic       m_mem_rw;
    logic [4:0] m_mem_dst;
    int         m_left;
    bit         last_pcw;

    function automatic logic [CW-1:0] mk(input bit rw, input bit mr, input bit mw,
                                         input bit rdst, input bit asrc, input bit br);
        logic [CW-1:0] c;
        c = '0;
        c[REGWRITE_B] = rw;
        c[MEMREAD_B]  = mr;
        c[MEMWRITE_B] = mw;
        c[REGDST_B]   = rdst;
        c[ALUSRC_B]   = asrc;
        c[BRANCH_B]   = br;
        c[ALUOP_LSB +: ALUOP_W] = 4'($urandom_range(0, 15));
        return c;
    endfunction

    task automatic model_reset();
        m_ex      = '0;
        m_mem_rw  = 1'b0;
        m_mem_dst = '0;
        m_left    = 0;
        last_pcw  = 1'b1;
`ifdef HAZARD_STATS_EN
        m_cnt = 0;
`endif
    endtask

    // Drives one ID cycle (called at posedge+2), records expectations, then
    // advances to the next posedge+2.
    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic ur, input logic br,
                        input logic [CW-1:0] ctrl, input logic fl);
        logic [4:0] dst;
        int   n;
        bit   stall;
        ex_t  nx;
        exp_t it;
        id_valid_i     = v;
        id_rs_i        = rs;
        id_rt_i        = rt;
        id_rd_i        = rd;
        id_uses_rt_i   = ur;
        id_is_branch_i = br;
        id_ctrl_i      = ctrl;
        id_rs_data_i   = $urandom;
        id_rt_data_i   = $urandom;
        id_imm_i       = $urandom;
        mem_regwrite_i = m_mem_rw;
        mem_dst_i      = m_mem_dst;
        flush_i        = fl;

        dst = m_ex.ctrl[REGDST_B] ? m_ex.rd : m_ex.rt;
        if (fl) begin
            stall  = 1'b0;
            m_left = 0;
        end else if (m_left > 0) begin
            stall  = 1'b1;
            m_left = m_left - 1;
        end else begin
            n = 0;
            if (v) begin
                if (m_ex.ctrl[MEMREAD_B] && dst != 0 && (dst == rs || (ur && dst == rt)))
                    n = 1;
                if (br && m_mem_rw && m_mem_dst != 0 && (m_mem_dst == rs || m_mem_dst == rt))
                    n = 1;
                if (br && m_ex.ctrl[REGWRITE_B] && dst != 0 && (dst == rs || dst == rt))
                    n = 2;
            end
            stall  = (n > 0);
            m_left = (n > 0) ? n - 1 : 0;
        end
        pcw_q.push_back(!stall);
`ifdef HAZARD_STATS_EN
        if (stall && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
        nx.rs   = rs;
        nx.rt   = rt;
        nx.rd   = rd;
        nx.a    = id_rs_data_i;
        nx.b    = id_rt_data_i;
        nx.imm  = id_imm_i;
        nx.valid = (fl || stall) ? 1'b0 : v;
        nx.ctrl  = (fl || stall || !v) ? '0 : ctrl;
        it.ex = nx;
        it.chk_fields = !(fl || stall);
        ex_q.push_back(it);

        m_mem_rw  = m_ex.ctrl[REGWRITE_B];
        m_mem_dst = dst;
        m_ex      = nx;
        last_pcw  = !stall;
        @(posedge clk);
        #2;
    endtask

    // Monitor: combinational stall outputs, sampled mid-cycle.
    initial begin
        bit e;
        forever begin
            @(negedge clk);
            if (pcw_q.size() > 0) begin
                e = pcw_q.pop_front();
                n_cmp++;
                if (pc_write_o !== e || if_id_write_o !== e) begin
                    n_bad++;
                    $display("FAIL pc_write: got pc_write=%0b if_id_write=%0b, want %0b at %0t",
                             pc_write_o, if_id_write_o, e, $time);
                end
            end
        end
    end

    // Monitor: registered EX outputs, sampled just after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (ex_q.size() > 0) begin
                x = ex_q.pop_front();
                n_cmp++;
                if (ex_valid_o !== x.ex.valid || ex_ctrl_o !== x.ex.ctrl) begin
                    n_bad++;
                    $display("FAIL ex_ctrl: got valid=%0b ctrl=%h, want valid=%0b ctrl=%h at %0t",
                             ex_valid_o, ex_ctrl_o, x.ex.valid, x.ex.ctrl, $time);
                end
                if (x.chk_fields) begin
                    n_cmp++;
                    if (ex_rs_o !== x.ex.rs || ex_rt_o !== x.ex.rt || ex_rd_o !== x.ex.rd ||
                        ex_rs_data_o !== x.ex.a || ex_rt_data_o !== x.ex.b || ex_imm_o !== x.ex.imm) begin
                        n_bad++;
                        $display("FAIL ex_fields: got rs=%0d rt=%0d rd=%0d a=%h b=%h imm=%h, want rs=%0d rt=%0d rd=%0d a=%h b=%h imm=%h",
                                 ex_rs_o, ex_rt_o, ex_rd_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
                                 x.ex.rs, x.ex.rt, x.ex.rd, x.ex.a, x.ex.b, x.ex.imm);
                    end
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        n_cmp++;
        if (ex_valid_o !== 1'b0 || ex_ctrl_o !== '0 || pc_write_o !== 1'b1 || if_id_write_o !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b ctrl=%h pc_write=%0b if_id_write=%0b, want 0/0/1/1",
                     tag, ex_valid_o, ex_ctrl_o, pc_write_o, if_id_write_o);
        end
    endtask

    logic [CW-1:0] LW, ADD, BEQ;
    logic [4:0]    r_rs, r_rt, r_rd;
    logic          r_v, r_ur, r_br, r_fl;
    logic [CW-1:0] r_ctrl;
    int            kind;

    initial begin
        rst_n = 1'b0;
        id_valid_i = 0; id_rs_i = 0; id_rt_i = 0; id_rd_i = 0;
        id_uses_rt_i = 0; id_is_branch_i = 0;
        id_rs_data_i = 0; id_rt_data_i = 0; id_imm_i = 0; id_ctrl_i = 0;
        mem_regwrite_i = 0; mem_dst_i = 0; flush_i = 0;
        model_reset();
        LW  = mk(1, 1, 0, 0, 1, 0);
        ADD = mk(1, 0, 0, 1, 0, 0);
        BEQ = mk(0, 0, 0, 0, 0, 1);
        #3;
        check_reset_state("reset");
        n_cmp++;
        if (ex_rs_o !== 0 || ex_rt_o !== 0 || ex_rd_o !== 0 || ex_rs_data_o !== 0 ||
            ex_rt_data_o !== 0 || ex_imm_o !== 0) begin
            n_bad++;
            $display("FAIL reset_fields: got rs=%0d rt=%0d rd=%0d a=%h b=%h imm=%h, want all 0",
                     ex_rs_o, ex_rt_o, ex_rd_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o);
        end
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // lw $2,0($1) ; add $3,$2,$4  (load-use, twice)
        repeat (2) begin
            step(1, 1, 2, 0, 0, 0, LW, 0);
            step(1, 2, 4, 3, 1, 0, ADD, 0);
            step(1, 2, 4, 3, 1, 0, ADD, 0);
            step(0, 0, 0, 0, 0, 0, '0, 0);
        end
        // add $5,$1,$1 ; beq $5,$0  (branch depends on EX result)
        step(1, 1, 1, 5, 1, 0, ADD, 0);
        repeat (3) step(1, 5, 0, 0, 1, 1, BEQ, 0);
`ifdef HAZARD_STATS_EN
        n_cmp++;
        if (stall_cnt_o !== 16'd4) begin
            n_bad++;
            $display("FAIL stall_cnt_4: got %0d, want 4", stall_cnt_o);
        end
`endif
        step(0, 0, 0, 0, 0, 0, '0, 0);
        step(0, 0, 0, 0, 0, 0, '0, 0);

        // lw $0 ; add $3,$0,$4  -> $0 never stalls
        step(1, 1, 0, 0, 0, 0, LW, 0);
        step(1, 0, 4, 3, 1, 0, ADD, 0);
        step(0, 0, 0, 0, 0, 0, '0, 0);

        // flush in the second branch stall cycle
        step(1, 1, 1, 5, 1, 0, ADD, 0);
        step(1, 5, 0, 0, 1, 1, BEQ, 0);
        step(1, 5, 0, 0, 1, 1, BEQ, 1);
        step(1, 7, 8, 9, 1, 0, ADD, 0);
        step(0, 0, 0, 0, 0, 0, '0, 0);

        // asynchronous reset in the middle of a two-cycle stall
        step(1, 1, 1, 5, 1, 0, ADD, 0);
        step(1, 5, 0, 0, 1, 1, BEQ, 0);
        rst_n = 1'b0;
        mem_regwrite_i = 1'b0;
        mem_dst_i = '0;
        #1;
        check_reset_state("reset_mid_stall");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #2;
        step(1, 5, 0, 0, 1, 1, BEQ, 0);
        step(0, 0, 0, 0, 0, 0, '0, 0);

        // random instruction stream over a small register set to force hazards
        r_v = 0; r_rs = 0; r_rt = 0; r_rd = 0; r_ur = 0; r_br = 0; r_ctrl = '0;
        for (int i = 0; i < 600; i++) begin
            if (last_pcw) begin
                kind = $urandom_range(0, 4);
                r_v  = 1'b1;
                r_rs = 5'($urandom_range(0, 3));
                r_rt = 5'($urandom_range(0, 3));
                r_rd = 5'($urandom_range(0, 3));
                r_ur = 1'b1;
                r_br = 1'b0;
                case (kind)
                    0: begin r_ctrl = mk(1, 1, 0, 0, 1, 0); r_ur = 1'b0; end
                    1: r_ctrl = mk(1, 0, 0, 1, 0, 0);
                    2: begin r_ctrl = mk(0, 0, 0, 0, 0, 1); r_br = 1'b1; end
                    3: r_ctrl = mk(0, 0, 1, 0, 1, 0);
                    default: begin
                        r_v = 1'b0;
                        r_br = 1'($urandom_range(0, 1));
                        r_ctrl = CW'($urandom);
                    end
                endcase
            end
            r_fl = ($urandom_range(0, 15) == 0);
            step(r_v, r_rs, r_rt, r_rd, r_ur, r_br, r_ctrl, r_fl);
        end
        step(0, 0, 0, 0, 0, 0, '0, 0);

`ifdef HAZARD_STATS_EN
        n_cmp++;
        if (stall_cnt_o !== 16'(m_cnt)) begin
            n_bad++;
            $display("FAIL stall_cnt: got %0d, want %0d", stall_cnt_o, m_cnt);
        end
`endif
        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
